// File: rtl/xor2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xor2_pkg : shared constants and parity helper for the xor2 family    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package xor2_pkg;

  localparam int XOR2_MAX_LATENCY   = 4;
  localparam int XOR2_DEFAULT_WIDTH = 1;

  // Widest vector the helper accepts; zero-extension does not change parity.
  localparam int XOR2_PAR_MAX_WIDTH = 64;

  function automatic logic xor2_parity(input logic [XOR2_PAR_MAX_WIDTH-1:0] v);
    logic p;
    p = 1'b0;
    for (int k = 0; k < XOR2_PAR_MAX_WIDTH; k++) begin
      p = p ^ v[k];
    end
    return p;
  endfunction

endpackage : xor2_pkg
`default_nettype wire

// File: rtl/xor2_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xor2_pipe : synchronous-reset delay line, DEPTH=0 is a pass-through  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module xor2_pipe
  import xor2_pkg::*;
#(
  parameter int WIDTH = XOR2_DEFAULT_WIDTH,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("xor2_pipe: WIDTH must be >= 1");
    end
    if (DEPTH < 0 || DEPTH > XOR2_MAX_LATENCY) begin : g_bad_depth
      $error("xor2_pipe: DEPTH out of range");
    end

    if (DEPTH == 0) begin : g_passthru
      // No storage at this depth, so clk and rst are intentionally unused.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = d;
        for (int k = 1; k < DEPTH; k++) begin
          stage_d[k] = stage_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (rst) begin
            stage_q[k] <= '0;
          end else begin
            stage_q[k] <= stage_d[k];
          end
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule : xor2_pipe
`default_nettype wire

// File: rtl/xor2_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xor2_core : bitwise XOR with parity and optional registered copy     |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module xor2_core
  import xor2_pkg::*;
#(
  parameter int WIDTH   = XOR2_DEFAULT_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic             o_par
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("xor2_core: WIDTH must be >= 1");
    end
    if (LATENCY < 0 || LATENCY > XOR2_MAX_LATENCY) begin : g_bad_latency
      $error("xor2_core: LATENCY must be in 0..4");
    end
  endgenerate

  assign o = i0 ^ i1;

  generate
    if (WIDTH <= XOR2_PAR_MAX_WIDTH) begin : g_par_fn
      logic [XOR2_PAR_MAX_WIDTH-1:0] w_o_ext;
      assign w_o_ext = XOR2_PAR_MAX_WIDTH'(o);
      assign o_par   = xor2_parity(w_o_ext);
    end else begin : g_par_wide
      assign o_par = ^o;
    end
  endgenerate

  xor2_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (LATENCY)
  ) u_pipe (
    .clk (clk),
    .rst (rst),
    .d   (o),
    .q   (o_q)
  );

endmodule : xor2_core
`default_nettype wire

// File: tb/tb_xor2_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_xor2_core : four parameterisations driven together vs. a model    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_xor2_core;

  localparam int c_nmax = 1024;
  localparam int c_lat [4] = '{1, 2, 3, 0};
  localparam int c_wid [4] = '{1, 8, 8, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [0:0] a0, b0, o0, q0;
  logic [7:0] a1, b1, o1, q1;
  logic [7:0] a2, b2, o2, q2;
  logic [3:0] a3, b3, o3, q3;
  logic       p0, p1, p2, p3;

  int n_chk = 0;
  int n_err = 0;

  // Per-edge history of operands (already XORed) and reset, one row per DUT.
  logic [7:0] xh [4][c_nmax];
  bit         rh [c_nmax];
  int         n_edge = 0;

  always #5 clk = ~clk;

  xor2_core #(.WIDTH(1), .LATENCY(1)) u_w1l1 (
    .clk(clk), .rst(rst), .i0(a0), .i1(b0), .o(o0), .o_q(q0), .o_par(p0));
  xor2_core #(.WIDTH(8), .LATENCY(2)) u_w8l2 (
    .clk(clk), .rst(rst), .i0(a1), .i1(b1), .o(o1), .o_q(q1), .o_par(p1));
  xor2_core #(.WIDTH(8), .LATENCY(3)) u_w8l3 (
    .clk(clk), .rst(rst), .i0(a2), .i1(b2), .o(o2), .o_q(q2), .o_par(p2));
  xor2_core #(.WIDTH(4), .LATENCY(0)) u_w4l0 (
    .clk(clk), .rst(rst), .i0(a3), .i1(b3), .o(o3), .o_q(q3), .o_par(p3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] mask(input int d, input logic [7:0] v);
    return v & 8'((1 << c_wid[d]) - 1);
  endfunction

  function automatic logic [7:0] cur_x(input int d);
    case (d)
      0:       return mask(0, 8'(a0 ^ b0));
      1:       return mask(1, a1 ^ b1);
      2:       return mask(2, a2 ^ b2);
      default: return mask(3, 8'(a3 ^ b3));
    endcase
  endfunction

  // Value sampled at edge m emerges after edge m+L-1 unless any reset hit that window.
  function automatic logic [7:0] exp_q(input int d);
    int lat;
    lat = c_lat[d];
    if (lat == 0) return cur_x(d);
    for (int e = n_edge - lat; e < n_edge; e++) begin
      if (e < 0) return 8'h00;
      if (rh[e]) return 8'h00;
    end
    return xh[d][n_edge - lat];
  endfunction

  task automatic check_comb();
    chk("w1_o",   32'(o0), 32'(cur_x(0)));
    chk("w1_par", 32'(p0), 32'($countones(cur_x(0)) % 2));
    chk("w8a_o",  32'(o1), 32'(cur_x(1)));
    chk("w8a_par",32'(p1), 32'($countones(cur_x(1)) % 2));
    chk("w8b_o",  32'(o2), 32'(cur_x(2)));
    chk("w8b_par",32'(p2), 32'($countones(cur_x(2)) % 2));
    chk("w4_o",   32'(o3), 32'(cur_x(3)));
    chk("w4_q",   32'(q3), 32'(cur_x(3)));
    chk("w4_par", 32'(p3), 32'($countones(cur_x(3)) % 2));
  endtask

  task automatic cycle(input logic r,
                       input logic [7:0] x0, input logic [7:0] y0,
                       input logic [7:0] x1, input logic [7:0] y1,
                       input logic [7:0] x2, input logic [7:0] y2,
                       input logic [7:0] x3, input logic [7:0] y3);
    rst = r;
    a0 = x0[0:0]; b0 = y0[0:0];
    a1 = x1;      b1 = y1;
    a2 = x2;      b2 = y2;
    a3 = x3[3:0]; b3 = y3[3:0];
    #1;
    check_comb();
    @(posedge clk);
    if (n_edge >= c_nmax) begin
      $display("FAIL history_overflow got=%0d expected=<%0d", n_edge, c_nmax);
      $fatal(1, "history overflow");
    end
    for (int d = 0; d < 4; d++) xh[d][n_edge] = cur_x(d);
    rh[n_edge] = r;
    n_edge++;
    @(negedge clk);
    chk("w1_q",  32'(q0), 32'(exp_q(0)));
    chk("w8a_q", 32'(q1), 32'(exp_q(1)));
    chk("w8b_q", 32'(q2), 32'(exp_q(2)));
    chk("w4_qs", 32'(q3), 32'(exp_q(3)));
  endtask

  initial begin
    logic [7:0] tt_a [4];
    logic [7:0] tt_b [4];
    logic [7:0] tt_o [4];
    tt_a = '{8'd1, 8'd1, 8'd0, 8'd0};
    tt_b = '{8'd1, 8'd0, 8'd1, 8'd0};
    tt_o = '{8'd0, 8'd1, 8'd1, 8'd0};

    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    a3 = 4'b1100; b3 = 4'b1010;
    #1;
    chk("l0_o",   32'(o3), 32'h6);
    chk("l0_q",   32'(q3), 32'h6);
    chk("l0_par", 32'(p3), 32'h0);
    a3 = '0; b3 = '0;
    #99;

    for (int k = 0; k < 4; k++) begin
      a0 = tt_a[k][0:0];
      b0 = tt_b[k][0:0];
      #10;
      chk("tt_o",   32'(o0), 32'(tt_o[k]));
      chk("tt_par", 32'(p0), 32'(tt_o[k]));
    end

    @(negedge clk);
    cycle(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_q1", 32'(q0), 32'h0);

    cycle(1'b0, 1, 0, 8'hA5, 8'h0F, 8'hFF, 8'h00, 0, 0);
    chk("l1_rise", 32'(q0), 32'h1);
    chk("vec_o",   32'(o1), 32'hAA);
    chk("vec_par", 32'(p1), 32'h0);
    cycle(1'b0, 1, 1, 8'hA5, 8'h0F, 0, 0, 0, 0);
    chk("l1_fall", 32'(q0), 32'h0);
    chk("vec_q",   32'(q1), 32'hAA);

    cycle(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst", 32'(q2), 32'h00);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("mid_hold", 32'(q2), 32'h00);
    end

    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 19) == 0),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule : tb_xor2_core
`default_nettype wire
